regfile_bypass_nlane: RTL and testbench
=======================================

// Module: regfile_bypass_nlane
// PURPOSE
//  Parametrised N-lane register file with operand forwarding and hazard stalls for the superscalar core.
//  Generalises the fixed 2-lane (p0/p1) forwarding path to LANES issue lanes and DEPTH in-flight stages.
//  Adds intra-bundle RAW stalls, late-result (load-use) stalls and flush.
//  Sits at decode/issue. Owns the architectural regfile and a tag pipeline mirroring the datapath stages.
// PARAMETERS
//  LANES      2   issue lanes per bundle; lane 0 is oldest in program order
//  NREGS      8   architectural registers
//  DW         16  data width
//  DEPTH      3   in-flight stages after issue; stage DEPTH commits to regfile
//  LATE_STG   2   first stage at which a late (load) result is valid; 1 < LATE_STG <= DEPTH
// PORTS
//  clk        in   1               clock, rising edge
//  rst_n      in   1               asynchronous, active-low reset
//  iss_valid  in   LANES           lane carries an instruction this cycle
//  iss_rs_a   in   LANES*RW        source A index per lane (RW=$clog2(NREGS))
//  iss_rs_b   in   LANES*RW        source B index per lane
//  iss_rd     in   LANES*RW        destination index per lane
//  iss_wen    in   LANES           lane writes iss_rd
//  iss_late   in   LANES           lane's result is valid only from stage LATE_STG
//  stg_data   in   DEPTH*LANES*DW  datapath result per stage s=1..DEPTH, per lane
//  flush      in   1               squash all un-committed work
//  iss_stall  out  LANES           lane not accepted this cycle; datapath inserts bubble
//  op_a       out  LANES*DW        resolved source A operand
//  op_b       out  LANES*DW        resolved source B operand
// BEHAVIOUR
//  - Reset (async, rst_n=0): all regfile entries = 0; all tag valids = 0.
//    Outputs follow combinationally: iss_stall=0 unless flush is high, op_a/op_b=0.
//  - Tag pipeline: tag{valid,rd,late}[s][l] for s=1..DEPTH. Every clock, stage s moves to s+1.
//    Stage 1 loads tag{iss_valid&iss_wen&~iss_stall, iss_rd, iss_late} per lane.
//    Stalled or invalid lanes enter as bubbles. No back-pressure beyond this.
//  - Operand resolve: combinational, same cycle as issue.
//    Candidates are valid tags with matching rd in stages 1..DEPTH, taking stg_data[s][l].
//    Priority: lowest s first (youngest); within a stage, highest l.
//    No hit -> regfile read. Operands of a stalled lane are don't-care.
//  - Late stall: if the winning hit for a used source has late=1 and s < LATE_STG, that lane stalls.
//  - Intra-bundle RAW stall: lane j stalls if some lane i<j with iss_valid&iss_wen has iss_rd equal to rs_a or rs_b of j.
//  - In-order rule: once any lane k stalls, every lane > k also stalls.
//    Lanes < k are accepted; the stalled remainder is re-presented next cycle by the fetch side.
//  - Commit: at clock edge, valid stage-DEPTH tags write stg_data[DEPTH][l] to regfile[rd].
//    Two lanes writing the same rd in one cycle -> higher lane wins.
//  - flush=1: iss_stall = all-ones; at the edge, tag valids of stages 1..DEPTH-1 clear.
//    Stage DEPTH still commits. Simultaneous flush and commit: the commit completes.
//  - Reset mid-operation: in-flight tags discarded, regfile zeroed; no partial commit.
//  - All forwarding and commit is full DW width, no sign or width conversion. No read-port limit.
// STRUCTURE
//  - kl_pipe_pkg: RW localparam function, typedef tag_t {logic valid; logic [RW-1:0] rd; logic late;}.
//    Also typedef fwd_sel_t {logic hit; stage; lane}.
//  - Sub-module bypass_sel: one instance per read port (2*LANES).
//    Inputs: tag array, rs index. Outputs: fwd_sel_t (priority encoder) and the late-hazard flag.
//  - Top holds regfile, tag shift register, stall chain and the data muxes.
// TESTING
//  1 Bundle writes R0=2 (lane0), R1=2 (lane1); next cycle lane0 reads R1,R0.
//    -> no stall; forwarded op_a=2, op_b=2 from stage 1.
//  2 Same bundle: lane0 writes R2, lane1 reads R2 and R4.
//    -> iss_stall=2'b10 for 1 cycle; lane1 re-issued next cycle with R2 forwarded from stage 1.
//  3 Lane0 late write R3; next cycle lane0 reads R3.
//    -> stall until the tag reaches LATE_STG (1 cycle at defaults), then op_a=stg_data[2][0].
//  4 One bundle writes R3=5 (lane0) and R3=7 (lane1); read R3 1 cycle and DEPTH+1 cycles later.
//    -> op=7 both times; regfile[3]=7.
//  5 Write R6=9, flush at stage 2; read R6 after DEPTH cycles.
//    -> regfile[6]=0, no forward hit. Repeat with the flush at stage 3 -> commit stands, R6=9.
//  6 Assert rst_n=0 for 1 cycle while three bundles are in flight.
//    -> all op reads return 0, iss_stall=0, no writes afterwards.

Source files
------------

// File: rtl/regfile_bypass_nlane_pkg.sv
// Shared types for the N-lane register file with operand forwarding.
// Tag and forward-select fields use fixed maximum widths. This lets the types
// live in a package while the top stays parametrised; unused upper bits stay zero.
package regfile_bypass_nlane_pkg;

  // Maximum register-index width carried in a tag (supports up to 256 registers)
  localparam int RD_W   = 8;
  // Width of the stage-number field of a forward select (1-based stage)
  localparam int STG_W  = 8;
  // Width of the lane-number field of a forward select
  localparam int LANE_W = 8;

  // Index width for a table of n entries, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One in-flight destination tag travelling alongside the datapath
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            late;
  } tag_t;

  // Winning forward source for one read port: stage is 1..DEPTH, lane is 0..LANES-1
  typedef struct packed {
    logic              hit;
    logic [STG_W-1:0]  stage;
    logic [LANE_W-1:0] lane;
  } fwd_sel_t;

endpackage

// File: rtl/regfile_bypass_nlane_bypass_sel.sv
// Forward-source priority encoder for a single read port.
// Scans every in-flight tag for a destination matching the source index.
// The youngest stage wins. Within one stage, the highest lane, being the
// latest in program order, wins. Also flags a winner whose late result is
// not yet valid.
module regfile_bypass_nlane_bypass_sel
  import regfile_bypass_nlane_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int DEPTH    = 3,
  parameter int LATE_STG = 2
) (
  input  tag_t [DEPTH-1:0][LANES-1:0] tags_i,
  input  logic [RD_W-1:0]             rs_i,
  output fwd_sel_t                    sel_o,
  output logic                        late_haz_o
);

  logic hit_s;
  logic win_late_s;

  // Priority scan from oldest to youngest so later matches overwrite earlier ones
  always_comb begin
    sel_o      = '0;
    win_late_s = 1'b0;
    hit_s      = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        hit_s       = tags_i[s][l].valid && (tags_i[s][l].rd == rs_i);
        sel_o.hit   = sel_o.hit | hit_s;
        sel_o.stage = hit_s ? STG_W'(s + 1) : sel_o.stage;
        sel_o.lane  = hit_s ? LANE_W'(l) : sel_o.lane;
        win_late_s  = hit_s ? tags_i[s][l].late : win_late_s;
      end
    end
  end

  // A late producer that has not yet reached its valid stage cannot be forwarded
  always_comb begin
    late_haz_o = sel_o.hit && win_late_s && (int'(sel_o.stage) < LATE_STG);
  end

endmodule

// File: rtl/regfile_bypass_nlane.sv
// N-lane architectural register file with operand forwarding and hazard stalls.
// Holds the regfile and a tag pipeline that mirrors the datapath stages.
// Each source operand resolves in the issue cycle, either from the youngest
// in-flight producer or from the regfile. Lanes stall in order on intra-bundle
// RAW hazards or on results that arrive too late to forward.
module regfile_bypass_nlane
  import regfile_bypass_nlane_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int NREGS    = 8,
  parameter int DW       = 16,
  parameter int DEPTH    = 3,
  parameter int LATE_STG = 2,
  localparam int RW      = idx_width(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES-1:0]            iss_valid,
  input  logic [LANES*RW-1:0]         iss_rs_a,
  input  logic [LANES*RW-1:0]         iss_rs_b,
  input  logic [LANES*RW-1:0]         iss_rd,
  input  logic [LANES-1:0]            iss_wen,
  input  logic [LANES-1:0]            iss_late,
  input  logic [DEPTH*LANES*DW-1:0]   stg_data,
  input  logic                        flush,
  output logic [LANES-1:0]            iss_stall,
  output logic [LANES*DW-1:0]         op_a,
  output logic [LANES*DW-1:0]         op_b
);

  // Tag pipeline: index s holds stage s+1, so index DEPTH-1 is the commit stage
  tag_t [DEPTH-1:0][LANES-1:0] tag_q;
  tag_t [DEPTH-1:0][LANES-1:0] tag_d;

  logic [DW-1:0] regfile_q [NREGS];
  logic [DW-1:0] regfile_d [NREGS];

  logic [RD_W-1:0] rs_a_ext_s [LANES];
  logic [RD_W-1:0] rs_b_ext_s [LANES];
  fwd_sel_t        sel_a_s    [LANES];
  fwd_sel_t        sel_b_s    [LANES];
  logic [LANES-1:0] late_a_s;
  logic [LANES-1:0] late_b_s;

  logic [LANES-1:0] own_stall_s;
  logic [LANES-1:0] stall_s;
  logic             raw_s;
  logic             prev_stall_s;

  logic [DW-1:0] rf_a_s;
  logic [DW-1:0] rf_b_s;
  logic [DW-1:0] fw_a_s;
  logic [DW-1:0] fw_b_s;
  logic          pick_a_s;
  logic          pick_b_s;

  // Two forward selectors per lane, one for each source operand
  for (genvar l = 0; l < LANES; l++) begin : g_port
    assign rs_a_ext_s[l] = RD_W'(iss_rs_a[l*RW +: RW]);
    assign rs_b_ext_s[l] = RD_W'(iss_rs_b[l*RW +: RW]);

    regfile_bypass_nlane_bypass_sel #(
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .LATE_STG (LATE_STG)
    ) u_sel_a (
      .tags_i     (tag_q),
      .rs_i       (rs_a_ext_s[l]),
      .sel_o      (sel_a_s[l]),
      .late_haz_o (late_a_s[l])
    );

    regfile_bypass_nlane_bypass_sel #(
      .LANES    (LANES),
      .DEPTH    (DEPTH),
      .LATE_STG (LATE_STG)
    ) u_sel_b (
      .tags_i     (tag_q),
      .rs_i       (rs_b_ext_s[l]),
      .sel_o      (sel_b_s[l]),
      .late_haz_o (late_b_s[l])
    );
  end

  // Stall chain: a lane stalls on its own hazard, on flush, or when any older lane stalls
  always_comb begin
    own_stall_s  = '0;
    stall_s      = '0;
    raw_s        = 1'b0;
    prev_stall_s = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      raw_s = 1'b0;
      for (int i = 0; i < j; i++) begin
        raw_s = raw_s | (iss_valid[i] & iss_wen[i] &
                         ((iss_rd[i*RW +: RW] == iss_rs_a[j*RW +: RW]) |
                          (iss_rd[i*RW +: RW] == iss_rs_b[j*RW +: RW])));
      end
      own_stall_s[j] = iss_valid[j] & (late_a_s[j] | late_b_s[j] | raw_s);
      stall_s[j]     = flush | own_stall_s[j] | prev_stall_s;
      prev_stall_s   = stall_s[j];
    end
  end

  assign iss_stall = stall_s;

  // Operand muxes: selected stage/lane result on a forward hit, regfile otherwise
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    rf_a_s   = '0;
    rf_b_s   = '0;
    fw_a_s   = '0;
    fw_b_s   = '0;
    pick_a_s = 1'b0;
    pick_b_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      rf_a_s = '0;
      rf_b_s = '0;
      for (int r = 0; r < NREGS; r++) begin
        rf_a_s = (iss_rs_a[l*RW +: RW] == RW'(r)) ? regfile_q[r] : rf_a_s;
        rf_b_s = (iss_rs_b[l*RW +: RW] == RW'(r)) ? regfile_q[r] : rf_b_s;
      end
      fw_a_s = '0;
      fw_b_s = '0;
      for (int s = 0; s < DEPTH; s++) begin
        for (int m = 0; m < LANES; m++) begin
          pick_a_s = sel_a_s[l].hit && (sel_a_s[l].stage == STG_W'(s + 1)) &&
                     (sel_a_s[l].lane == LANE_W'(m));
          pick_b_s = sel_b_s[l].hit && (sel_b_s[l].stage == STG_W'(s + 1)) &&
                     (sel_b_s[l].lane == LANE_W'(m));
          fw_a_s   = pick_a_s ? stg_data[(s*LANES + m)*DW +: DW] : fw_a_s;
          fw_b_s   = pick_b_s ? stg_data[(s*LANES + m)*DW +: DW] : fw_b_s;
        end
      end
      op_a[l*DW +: DW] = sel_a_s[l].hit ? fw_a_s : rf_a_s;
      op_b[l*DW +: DW] = sel_b_s[l].hit ? fw_b_s : rf_b_s;
    end
  end

  // Next tag state: accepted writers enter stage 1, older tags advance, flush kills non-committing tags
  always_comb begin
    tag_d = '0;
    for (int l = 0; l < LANES; l++) begin
      tag_d[0][l].valid = iss_valid[l] & iss_wen[l] & ~stall_s[l];
      tag_d[0][l].rd    = RD_W'(iss_rd[l*RW +: RW]);
      tag_d[0][l].late  = iss_late[l];
      for (int s = 1; s < DEPTH; s++) begin
        tag_d[s][l]       = tag_q[s-1][l];
        tag_d[s][l].valid = tag_q[s-1][l].valid & ~flush;
      end
    end
  end

  // Next regfile state: commit-stage writers in lane order so the highest lane wins a collision
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regfile_d[r] = regfile_q[r];
    end
    for (int l = 0; l < LANES; l++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (tag_q[DEPTH-1][l].valid && (tag_q[DEPTH-1][l].rd == RD_W'(r))) begin
          regfile_d[r] = stg_data[((DEPTH-1)*LANES + l)*DW +: DW];
        end else begin
          regfile_d[r] = regfile_d[r];
        end
      end
    end
  end

  // State registers: reset discards in-flight tags and zeroes the regfile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      for (int r = 0; r < NREGS; r++) begin
        regfile_q[r] <= '0;
      end
    end else begin
      tag_q <= tag_d;
      for (int r = 0; r < NREGS; r++) begin
        regfile_q[r] <= regfile_d[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_bypass_nlane.sv
// Self-checking bench for regfile_bypass_nlane: directed scenarios followed by
// random bundles, compared against a queue-based model of in-flight writes.
module tb_regfile_bypass_nlane;

  localparam int LANES    = 2;
  localparam int NREGS    = 8;
  localparam int DW       = 16;
  localparam int DEPTH    = 3;
  localparam int LATE_STG = 2;
  localparam int RW       = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [LANES-1:0]          iss_valid = '0;
  logic [LANES*RW-1:0]       iss_rs_a  = '0;
  logic [LANES*RW-1:0]       iss_rs_b  = '0;
  logic [LANES*RW-1:0]       iss_rd    = '0;
  logic [LANES-1:0]          iss_wen   = '0;
  logic [LANES-1:0]          iss_late  = '0;
  logic [DEPTH*LANES*DW-1:0] stg_data  = '0;
  logic                      flush     = 1'b0;
  logic [LANES-1:0]          iss_stall;
  logic [LANES*DW-1:0]       op_a;
  logic [LANES*DW-1:0]       op_b;

  regfile_bypass_nlane #(
    .LANES(LANES), .NREGS(NREGS), .DW(DW), .DEPTH(DEPTH), .LATE_STG(LATE_STG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rs_a(iss_rs_a),
    .iss_rs_b(iss_rs_b), .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_late(iss_late),
    .stg_data(stg_data), .flush(flush), .iss_stall(iss_stall), .op_a(op_a), .op_b(op_b)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight writes with their age in stages
  typedef struct {
    int rd;
    bit late;
    int lane;
    int age;
  } inflight_t;

  inflight_t        fly[$];
  logic [DW-1:0]    ref_rf [NREGS];
  logic [LANES-1:0] exp_stall;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fly.delete();
    for (int r = 0; r < NREGS; r++) ref_rf[r] = '0;
  endtask

  task automatic set_lane(input int l, input bit v, input int ra, input int rb,
                          input int rd, input bit w, input bit lt);
    iss_valid[l]          = v;
    iss_rs_a[l*RW +: RW]  = RW'(ra);
    iss_rs_b[l*RW +: RW]  = RW'(rb);
    iss_rd[l*RW +: RW]    = RW'(rd);
    iss_wen[l]            = w;
    iss_late[l]           = lt;
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < LANES; l++) set_lane(l, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic rand_sd();
    for (int i = 0; i < DEPTH*LANES; i++) stg_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic set_sd(input int s, input int l, input logic [DW-1:0] v);
    stg_data[((s-1)*LANES + l)*DW +: DW] = v;
  endtask

  // Youngest in-flight producer of rs (ties: highest lane), else the architectural value
  task automatic resolve(input int rs, output logic [DW-1:0] val, output bit late_haz);
    int best;
    best = -1;
    val = ref_rf[rs];
    late_haz = 1'b0;
    foreach (fly[k]) begin
      if (fly[k].rd == rs) begin
        if (best < 0 || fly[k].age < fly[best].age ||
            (fly[k].age == fly[best].age && fly[k].lane > fly[best].lane)) best = k;
      end
    end
    if (best >= 0) begin
      val = stg_data[((fly[best].age - 1)*LANES + fly[best].lane)*DW +: DW];
      late_haz = fly[best].late && (fly[best].age < LATE_STG);
    end
  endtask

  // Compare stall vector and the operands of every accepted lane
  task automatic eval();
    int k;
    bit la, lb, raw;
    logic [DW-1:0] ea [LANES];
    logic [DW-1:0] eb [LANES];
    #1;
    k = LANES;
    for (int j = 0; j < LANES; j++) begin
      resolve(int'(iss_rs_a[j*RW +: RW]), ea[j], la);
      resolve(int'(iss_rs_b[j*RW +: RW]), eb[j], lb);
      raw = 1'b0;
      for (int i = 0; i < j; i++)
        if (iss_valid[i] && iss_wen[i] &&
            (iss_rd[i*RW +: RW] == iss_rs_a[j*RW +: RW] ||
             iss_rd[i*RW +: RW] == iss_rs_b[j*RW +: RW])) raw = 1'b1;
      if (iss_valid[j] && (la || lb || raw) && k == LANES) k = j;
    end
    for (int j = 0; j < LANES; j++) exp_stall[j] = flush || (j >= k);
    check("stall", 32'(iss_stall), 32'(exp_stall));
    for (int j = 0; j < LANES; j++) begin
      if (iss_valid[j] && !exp_stall[j]) begin
        check("op_a", 32'(op_a[j*DW +: DW]), 32'(ea[j]));
        check("op_b", 32'(op_b[j*DW +: DW]), 32'(eb[j]));
      end
    end
  endtask

  // Advance one clock and apply commit/flush/issue to the model
  task automatic tick();
    inflight_t nq[$];
    inflight_t e;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      foreach (fly[k])
        if (fly[k].age == DEPTH)
          ref_rf[fly[k].rd] = stg_data[((DEPTH-1)*LANES + fly[k].lane)*DW +: DW];
      foreach (fly[k]) begin
        if (fly[k].age < DEPTH && !flush) begin
          e = fly[k];
          e.age = e.age + 1;
          nq.push_back(e);
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (iss_valid[l] && iss_wen[l] && !exp_stall[l]) begin
          e.rd = int'(iss_rd[l*RW +: RW]);
          e.late = iss_late[l];
          e.lane = l;
          e.age = 1;
          nq.push_back(e);
        end
      end
      fly = nq;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_lanes();
      rand_sd();
      eval();
      tick();
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // Reset state
    clear_lanes();
    set_lane(0, 1'b1, 3, 4, 0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 6, 7, 0, 1'b0, 1'b0);
    eval();
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(1);

    // 1: two-lane writes forwarded from stage 1
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 5, 5, 0, 1'b1, 1'b0);
    set_lane(1, 1'b1, 5, 5, 1, 1'b1, 1'b0);
    eval(); check("t1_issue", 32'(iss_stall), 32'd0); tick();
    clear_lanes(); rand_sd(); set_sd(1, 0, 16'd2); set_sd(1, 1, 16'd2);
    set_lane(0, 1'b1, 1, 0, 0, 1'b0, 1'b0);
    eval();
    check("t1_stall", 32'(iss_stall), 32'd0);
    check("t1_op_a", 32'(op_a[DW-1:0]), 32'd2);
    check("t1_op_b", 32'(op_b[DW-1:0]), 32'd2);
    tick(); idle(DEPTH);

    // 2: intra-bundle RAW stalls lane 1, re-presented next cycle
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 6, 6, 2, 1'b1, 1'b0);
    set_lane(1, 1'b1, 2, 4, 7, 1'b0, 1'b0);
    eval(); check("t2_stall", 32'(iss_stall), 32'd2); tick();
    clear_lanes(); rand_sd(); set_sd(1, 0, 16'h1234);
    set_lane(0, 1'b1, 2, 4, 7, 1'b0, 1'b0);
    eval();
    check("t2_restall", 32'(iss_stall), 32'd0);
    check("t2_fwd", 32'(op_a[DW-1:0]), 32'h1234);
    tick(); idle(DEPTH);

    // 3: late result stalls until it reaches its valid stage
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 6, 6, 3, 1'b1, 1'b1);
    eval(); tick();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 3, 3, 0, 1'b0, 1'b0);
    eval(); check("t3_late_stall", 32'(iss_stall), 32'd3); tick();
    clear_lanes(); rand_sd(); set_sd(2, 0, 16'h0abc);
    set_lane(0, 1'b1, 3, 3, 0, 1'b0, 1'b0);
    eval();
    check("t3_released", 32'(iss_stall), 32'd0);
    check("t3_op", 32'(op_a[DW-1:0]), 32'h0abc);
    tick(); idle(DEPTH);

    // 4: same-rd collision in one bundle, higher lane wins forward and commit
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 6, 6, 3, 1'b1, 1'b0);
    set_lane(1, 1'b1, 7, 7, 3, 1'b1, 1'b0);
    eval(); tick();
    clear_lanes(); rand_sd(); set_sd(1, 0, 16'd5); set_sd(1, 1, 16'd7);
    set_lane(0, 1'b1, 3, 3, 0, 1'b0, 1'b0);
    eval(); check("t4_fwd", 32'(op_a[DW-1:0]), 32'd7); tick();
    idle(1);
    clear_lanes(); rand_sd(); set_sd(3, 0, 16'd5); set_sd(3, 1, 16'd7);
    eval(); tick();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 3, 3, 0, 1'b0, 1'b0);
    eval();
    check("t4_rf_a", 32'(op_a[DW-1:0]), 32'd7);
    check("t4_rf_b", 32'(op_b[DW-1:0]), 32'd7);
    tick(); idle(DEPTH);

    // 5a: flush while the write sits at stage 2 -> no commit
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 0, 0, 6, 1'b1, 1'b0);
    eval(); tick();
    idle(1);
    clear_lanes(); rand_sd(); flush = 1'b1;
    set_lane(0, 1'b1, 1, 1, 5, 1'b1, 1'b0);
    eval(); check("t5_flush_stall", 32'(iss_stall), 32'd3); tick();
    idle(1);
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 6, 6, 0, 1'b0, 1'b0);
    eval(); check("t5_killed", 32'(op_a[DW-1:0]), 32'd0); tick();
    idle(DEPTH);

    // 5b: flush while the write sits at stage 3 -> commit stands
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 0, 0, 6, 1'b1, 1'b0);
    eval(); tick();
    idle(2);
    clear_lanes(); rand_sd(); set_sd(3, 0, 16'd9); flush = 1'b1;
    eval(); tick();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 6, 6, 0, 1'b0, 1'b0);
    eval(); check("t5_commit", 32'(op_a[DW-1:0]), 32'd9); tick();
    idle(DEPTH);

    // 6: reset with three bundles in flight
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 3, 3, 1, 1'b1, 1'b0); set_lane(1, 1'b1, 3, 3, 2, 1'b1, 1'b0);
    eval(); tick();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 3, 3, 5, 1'b1, 1'b0); set_lane(1, 1'b1, 3, 3, 4, 1'b1, 1'b0);
    eval(); tick();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 3, 3, 7, 1'b1, 1'b0); set_lane(1, 1'b1, 3, 3, 0, 1'b1, 1'b0);
    eval(); tick();
    rst_n = 1'b0;
    model_clear();
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 1, 2, 0, 1'b0, 1'b0); set_lane(1, 1'b1, 5, 7, 0, 1'b0, 1'b0);
    eval();
    check("t6_stall", 32'(iss_stall), 32'd0);
    check("t6_op_a", 32'(op_a), 32'd0);
    check("t6_op_b", 32'(op_b), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(DEPTH + 1);
    clear_lanes(); rand_sd();
    set_lane(0, 1'b1, 1, 2, 0, 1'b0, 1'b0); set_lane(1, 1'b1, 5, 7, 0, 1'b0, 1'b0);
    eval();
    check("t6_after_a", 32'(op_a), 32'd0);
    check("t6_after_b", 32'(op_b), 32'd0);
    tick();

    // Random bundles against the model
    for (int c = 0; c < 400; c++) begin
      rand_sd();
      for (int l = 0; l < LANES; l++)
        set_lane(l, ($urandom_range(0, 3) != 0), int'($urandom_range(0, NREGS-1)),
                 int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      flush = ($urandom_range(0, 19) == 0);
      eval();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
